// File: rtl/calib_ctrl_if.sv
// Command handshake between the host and the calibration controller.
interface calib_ctrl_if;
    logic        cmd_vld;
    logic [1:0]  cmd;
    logic [11:0] cmd_data;
    logic        cmd_rdy;

    modport master (output cmd_vld, output cmd, output cmd_data, input  cmd_rdy);
    modport slave  (input  cmd_vld, input  cmd, input  cmd_data, output cmd_rdy);
endinterface

// File: rtl/calib_ctrl.sv
// Calibration sequencer: drives the ADC start, the offset/gain datapath and
// the EEPROM write strobe. All arithmetic lives in the datapath; this block
// only steps through states and registers the final result.
module calib_ctrl #(
    parameter int EEP_WAIT    = 16,
    parameter int CNV_TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         nRST,
    calib_ctrl_if.slave  cif,
    output logic         strt_cnv,
    input  logic         cnv_cmplt,
    output logic         addr,
    output logic         mult,
    output logic         WE,
    output logic         wrtTmp,
    output logic [11:0]  wdata,
    input  logic [11:0]  res,
    output logic [11:0]  temp,
    output logic         res_vld,
    output logic         err
);

    localparam int CMAX = (EEP_WAIT > CNV_TIMEOUT) ? EEP_WAIT : CNV_TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);
    // Last count value before the wait expires; the counter starts at 0.
    localparam logic [CW-1:0] TO_LAST = CW'(CNV_TIMEOUT - 1);
    localparam logic [CW-1:0] WR_LAST = CW'(EEP_WAIT - 1);

    typedef enum logic [2:0] {
        IDLE, CNV, WAIT_CNV, ADD, MUL, WR, WAIT_WR
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    cmd_q, cmd_d;
    logic [11:0]   wdata_q, wdata_d;
    logic [11:0]   temp_q, temp_d;
    logic          res_vld_q, res_vld_d;
    logic          err_q, err_d;

    // State and registered outputs; synchronous reset aborts any sequence.
    always_ff @(posedge clk) begin
        if (!nRST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cmd_q     <= 2'b00;
            wdata_q   <= 12'h000;
            temp_q    <= 12'h000;
            res_vld_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            wdata_q   <= wdata_d;
            temp_q    <= temp_d;
            res_vld_q <= res_vld_d;
            err_q     <= err_d;
        end
    end

    // Next-state: sequencing, wait counting, result capture and error flag.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        wdata_d   = wdata_q;
        temp_d    = temp_q;
        res_vld_d = 1'b0;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (cif.cmd_vld) begin
                    cmd_d = cif.cmd;
                    err_d = 1'b0;
                    cnt_d = '0;
                    case (cif.cmd)
                        2'b00:        state_d = CNV;
                        2'b01, 2'b10: begin
                            state_d = WR;
                            wdata_d = cif.cmd_data;
                        end
                        default:      err_d = 1'b1;  // reserved: flag and stay
                    endcase
                end
            end
            CNV: begin
                state_d = WAIT_CNV;
                cnt_d   = '0;
            end
            WAIT_CNV: begin
                // Completion is checked first so it wins on the timeout edge.
                if (cnv_cmplt) begin
                    state_d = ADD;
                end else if (cnt_q == TO_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ADD: state_d = MUL;
            MUL: begin
                state_d   = IDLE;
                temp_d    = res;
                res_vld_d = 1'b1;
            end
            WR: begin
                state_d = WAIT_WR;
                cnt_d   = '0;
            end
            WAIT_WR: begin
                if (cnt_q == WR_LAST) state_d = IDLE;
                else                  cnt_d   = cnt_q + CW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore decode of the datapath and handshake strobes.
    always_comb begin
        cif.cmd_rdy = 1'b0;
        strt_cnv    = 1'b0;
        addr        = 1'b0;
        mult        = 1'b0;
        WE          = 1'b0;
        wrtTmp      = 1'b0;
        case (state_q)
            IDLE:    cif.cmd_rdy = 1'b1;
            CNV:     strt_cnv    = 1'b1;
            ADD:     wrtTmp      = 1'b1;
            MUL: begin
                addr = 1'b1;
                mult = 1'b1;
            end
            WR: begin
                WE   = 1'b1;
                addr = cmd_q[1];
            end
            WAIT_WR: addr = cmd_q[1];
            default: ;
        endcase
    end

    assign wdata   = wdata_q;
    assign temp    = temp_q;
    assign res_vld = res_vld_q;
    assign err     = err_q;

endmodule

// File: tb/tb_calib_ctrl.sv
// Bench for calib_ctrl with a behavioural offset/gain datapath and EEPROM.
module tb_calib_ctrl;

    logic        clk = 1'b0;
    logic        nRST = 1'b0;
    logic        strt_cnv, cnv_cmplt, addr, mult, WE, wrtTmp, res_vld, err;
    logic [11:0] wdata, res, temp;
    logic [11:0] a2d = 12'h000;

    calib_ctrl_if cif ();

    calib_ctrl #(.EEP_WAIT(16), .CNV_TIMEOUT(8)) dut (
        .clk(clk), .nRST(nRST), .cif(cif),
        .strt_cnv(strt_cnv), .cnv_cmplt(cnv_cmplt),
        .addr(addr), .mult(mult), .WE(WE), .wrtTmp(wrtTmp),
        .wdata(wdata), .res(res), .temp(temp),
        .res_vld(res_vld), .err(err)
    );

    always #5 clk = ~clk;

    // Datapath model: EEPROM holds offset/gain, tmp holds a2d+offset,
    // MUL yields tmp*gain with gain 0x800 meaning unity.
    logic [11:0] eep_off = 12'h000;
    logic [11:0] eep_gain = 12'h800;
    logic [11:0] tmp = 12'h000;
    logic [23:0] prod;
    logic [12:0] sum;

    always @(posedge clk) begin
        if (WE && !addr) eep_off <= wdata;
        if (WE && addr)  eep_gain <= wdata;
        if (wrtTmp)      tmp <= res;
    end

    always_comb begin
        prod = ({12'h000, tmp} * {12'h000, eep_gain}) >> 11;
        sum  = {1'b0, a2d} + {1'b0, (addr ? eep_gain : eep_off)};
        if (mult) res = (prod > 24'h000FFF) ? 12'hFFF : prod[11:0];
        else      res = sum[12] ? 12'hFFF : sum[11:0];
    end

    int errors = 0;
    int checks = 0;
    logic [11:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, expv);
        end
    endtask

    // Scoreboard: every res_vld pulse must match the oldest pending result.
    logic [11:0] exp_t;
    always @(negedge clk) begin
        if (res_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_res_vld", {20'h0, temp}, 32'hFFFF_FFFF);
            end else begin
                exp_t = exp_q.pop_front();
                chk("sb_temp", {20'h0, temp}, {20'h0, exp_t});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  cmd;
        logic [11:0] data;
        logic [11:0] a2d;
        int          wait_cyc;
        logic [11:0] expv;
    } vec_t;

    vec_t vecs[9];

    // Wait (bounded) for IDLE, then present a command for one edge.
    task automatic issue(input logic [1:0] c, input logic [11:0] d);
        int n = 0;
        while (cif.cmd_rdy !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (cif.cmd_rdy !== 1'b1) chk("issue_rdy_timeout", 0, 1);
        cif.cmd_vld  = 1'b1;
        cif.cmd      = c;
        cif.cmd_data = d;
        @(negedge clk);
        cif.cmd_vld  = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        int we_cnt;
        issue(v.cmd, v.data);
        case (v.cmd)
            2'b00: begin
                chk($sformatf("v%0d_err_clr", idx), err, 0);
                chk($sformatf("v%0d_strt_cnv", idx), strt_cnv, 1);
                repeat (v.wait_cyc + 1) @(negedge clk);
                a2d = v.a2d;
                cnv_cmplt = 1'b1;
                exp_q.push_back(v.expv);
                @(negedge clk);
                cnv_cmplt = 1'b0;
                chk($sformatf("v%0d_add", idx), {wrtTmp, mult, addr}, 3'b100);
                @(negedge clk);
                chk($sformatf("v%0d_mul", idx), {wrtTmp, mult, addr}, 3'b011);
                @(negedge clk);
                chk($sformatf("v%0d_latency", idx), {res_vld, cif.cmd_rdy}, 2'b11);
                @(negedge clk);
                chk($sformatf("v%0d_res_vld_1cyc", idx), res_vld, 0);
            end
            2'b01, 2'b10: begin
                chk($sformatf("v%0d_err_clr", idx), err, 0);
                chk($sformatf("v%0d_we_addr", idx), {WE, addr}, {1'b1, v.cmd[1]});
                chk($sformatf("v%0d_wdata", idx), wdata, v.data);
                @(negedge clk);
                n = 0;
                we_cnt = 0;
                while (cif.cmd_rdy !== 1'b1 && n < 40) begin
                    n++;
                    if (WE) we_cnt++;
                    @(negedge clk);
                end
                chk($sformatf("v%0d_wait_wr_len", idx), n, 16);
                chk($sformatf("v%0d_we_once", idx), we_cnt, 0);
                chk($sformatf("v%0d_wdata_hold", idx), wdata, v.data);
            end
            default: begin
                chk($sformatf("v%0d_rsvd", idx), {err, cif.cmd_rdy, strt_cnv, WE}, 4'b1100);
                @(negedge clk);
                chk($sformatf("v%0d_err_sticky", idx), {err, cif.cmd_rdy}, 2'b11);
            end
        endcase
    endtask

    initial begin
        int n;
        int cnt_a;
        int cnt_b;
        cif.cmd_vld  = 1'b0;
        cif.cmd      = 2'b00;
        cif.cmd_data = 12'h000;
        cnv_cmplt    = 1'b0;

        //          cmd    data     a2d      wait expected temp
        vecs[0] = '{2'b00, 12'h000, 12'h123, 2, 12'h123};  // power-up convert
        vecs[1] = '{2'b01, 12'h010, 12'h000, 0, 12'h000};  // offset 0x010
        vecs[2] = '{2'b00, 12'h000, 12'h123, 0, 12'h133};
        vecs[3] = '{2'b01, 12'h000, 12'h000, 0, 12'h000};  // offset 0
        vecs[4] = '{2'b10, 12'hC00, 12'h000, 0, 12'h000};  // gain 1.5
        vecs[5] = '{2'b00, 12'h000, 12'h100, 1, 12'h180};
        vecs[6] = '{2'b11, 12'h000, 12'h000, 0, 12'h000};  // reserved
        vecs[7] = '{2'b10, 12'h800, 12'h000, 0, 12'h000};  // gain 1.0
        vecs[8] = '{2'b00, 12'h000, 12'h200, 7, 12'h200};  // cmplt on timeout edge

        repeat (3) @(negedge clk);
        chk("rst_state", {cif.cmd_rdy, strt_cnv, WE, wrtTmp, res_vld, err}, 6'b100000);
        chk("rst_regs", {temp, wdata}, 24'h000000);
        nRST = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Timeout: 8 WAIT_CNV cycles, then back to IDLE with err.
        issue(2'b00, 12'h000);
        n = 0;
        cnt_a = 0;
        while (cif.cmd_rdy !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
            if (res_vld) cnt_a++;
        end
        chk("to_len", n, 9);
        chk("to_err_temp", {err, res_vld, temp}, {1'b1, 1'b0, 12'h200});
        chk("to_no_res_vld", cnt_a, 0);
        @(negedge clk);
        chk("to_err_sticky", err, 1);
        run_vec('{2'b00, 12'h000, 12'h050, 0, 12'h050}, 9);

        // Reset in WAIT_CNV, then a stray completion.
        issue(2'b00, 12'h000);
        @(negedge clk);
        nRST = 1'b0;
        @(negedge clk);
        nRST = 1'b1;
        chk("rwc_temp_rst", temp, 12'h000);
        a2d = 12'h3AB;
        cnv_cmplt = 1'b1;
        @(negedge clk);
        cnv_cmplt = 1'b0;
        cnt_a = 0;
        cnt_b = 0;
        for (int k = 0; k < 5; k++) begin
            if (wrtTmp)  cnt_a++;
            if (res_vld) cnt_b++;
            @(negedge clk);
        end
        chk("rwc_no_wrtTmp", cnt_a, 0);
        chk("rwc_no_res_vld", cnt_b, 0);
        chk("rwc_idle", {cif.cmd_rdy, temp}, {1'b1, 12'h000});

        // cmd_vld during WAIT_WR is dropped, not queued.
        issue(2'b01, 12'h000);
        @(negedge clk);
        cif.cmd_vld = 1'b1;
        cif.cmd     = 2'b00;
        @(negedge clk);
        cif.cmd_vld = 1'b0;
        cnt_a = 0;
        for (int k = 0; k < 30; k++) begin
            if (strt_cnv) cnt_a++;
            @(negedge clk);
        end
        chk("ww_pulse_ignored", cnt_a, 0);
        chk("ww_back_idle", cif.cmd_rdy, 1);

        // Reset in WAIT_WR: no second WE strobe, wdata cleared.
        issue(2'b10, 12'h800);
        @(negedge clk);
        nRST = 1'b0;
        @(negedge clk);
        nRST = 1'b1;
        cnt_a = 0;
        for (int k = 0; k < 20; k++) begin
            if (WE) cnt_a++;
            @(negedge clk);
        end
        chk("rww_no_we", cnt_a, 0);
        chk("rww_wdata", {cif.cmd_rdy, wdata}, {1'b1, 12'h000});

        chk("sb_drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
